// File: rtl/hdmi_pkg.sv
// Shared HDMI definitions for the period scheduler and the transmitter.
// Holds the period encoding, CTL pattern for the video preamble, default
// sequence lengths and the video guard band characters.
package hdmi_pkg;

    typedef enum logic [1:0] {
        PERIOD_CONTROL  = 2'd0,
        PERIOD_PREAMBLE = 2'd1,
        PERIOD_GUARD    = 2'd2,
        PERIOD_VIDEO    = 2'd3
    } period_e;

    // CTL3..CTL0 pattern announcing a video data period
    localparam logic [3:0] VIDEO_PREAMBLE_CTL = 4'b0001;

    localparam int DEFAULT_PREAMBLE_LEN = 8;
    localparam int DEFAULT_GUARD_LEN    = 2;
    localparam int DEFAULT_MIN_CTL_LEN  = 12;

    // Video leading guard band TMDS characters, per channel
    localparam logic [9:0] VIDEO_GB_CH0 = 10'b1011001100;
    localparam logic [9:0] VIDEO_GB_CH1 = 10'b0100110011;
    localparam logic [9:0] VIDEO_GB_CH2 = 10'b1011001100;

endpackage

// File: rtl/hdmi_delay_line.sv
// Fixed-depth shift register delaying a bus by DEPTH clock cycles.
// Reset clears every stage so the output is all-zero for DEPTH cycles after reset.
module hdmi_delay_line #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    // Shift one stage per clock; reset flushes the whole line
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/hdmi_period_scheduler.sv
// HDMI period scheduler: delays the pixel/sync stream by PREAMBLE_LEN+GUARD_LEN
// cycles and, seeing each de rise that far ahead, replaces the tail of the
// blanking run with the video preamble and leading guard band.
// Build option HDMI_PERIOD_HDMI_MODE_EN: defined = HDMI period insertion,
// undefined = DVI mode (CONTROL/VIDEO only, ctl and timing_err held at 0,
// same latency).
module hdmi_period_scheduler
    import hdmi_pkg::*;
#(
    parameter int PREAMBLE_LEN = DEFAULT_PREAMBLE_LEN,
    parameter int GUARD_LEN    = DEFAULT_GUARD_LEN,
    parameter int MIN_CTL_LEN  = DEFAULT_MIN_CTL_LEN
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       de,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [7:0] pixel_data_0,
    input  logic [7:0] pixel_data_1,
    input  logic [7:0] pixel_data_2,
    output logic       de_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic [7:0] pixel_data_0_o,
    output logic [7:0] pixel_data_1_o,
    output logic [7:0] pixel_data_2_o,
    output logic [1:0] period,
    output logic [3:0] ctl,
    output logic       timing_err
);

    localparam int L     = PREAMBLE_LEN + GUARD_LEN;
    localparam int SEQ_W = (L > 1) ? $clog2(L) : 1;
    localparam int DL_W  = 27;

    if (MIN_CTL_LEN < PREAMBLE_LEN + GUARD_LEN) begin : g_cfg_check
        $error("MIN_CTL_LEN must be at least PREAMBLE_LEN+GUARD_LEN");
    end

    logic [DL_W-1:0] w_dl_in;
    logic [DL_W-1:0] w_dl_out;

    assign w_dl_in = {de, hsync, vsync, pixel_data_2, pixel_data_1, pixel_data_0};

    hdmi_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (L)
    ) u_delay (
        .i_clk  (pixel_clk),
        .i_rst  (rst),
        .i_data (w_dl_in),
        .o_data (w_dl_out)
    );

    assign {de_o, hsync_o, vsync_o, pixel_data_2_o, pixel_data_1_o, pixel_data_0_o} = w_dl_out;

`ifdef HDMI_PERIOD_HDMI_MODE_EN
    localparam int RUN_W = $clog2(MIN_CTL_LEN + 1);

    typedef enum logic [1:0] {
        ST_CONTROL,
        ST_PREAMBLE,
        ST_GUARD,
        ST_VIDEO
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [SEQ_W-1:0] r_seq;
    logic [SEQ_W-1:0] w_seq_nxt;
    logic [RUN_W-1:0] r_run;
    logic             r_de_prev;
    logic             r_err;
    logic             w_trig;
    logic             w_trig_ok;
    logic             w_idle;
    period_e          w_period;
    logic [3:0]       w_ctl;

    // The input is L cycles ahead of the output, so a de rise seen here is
    // the first cycle of the preamble on the output side.
    assign w_trig    = de && !r_de_prev;
    assign w_trig_ok = w_trig && (r_run == RUN_W'(MIN_CTL_LEN));

    // VIDEO with de_o already low behaves exactly like CONTROL
    assign w_idle = (r_state == ST_CONTROL) || ((r_state == ST_VIDEO) && !de_o);

    // Count the blanking run preceding each de rise, saturating at MIN_CTL_LEN
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_run     <= '0;
            r_de_prev <= 1'b0;
        end else begin
            r_de_prev <= de;
            if (de) begin
                r_run <= '0;
            end else if (r_run != RUN_W'(MIN_CTL_LEN)) begin
                r_run <= r_run + 1'b1;
            end
        end
    end

    // Flag a de rise whose preceding blanking is too short for insertion
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_trig && !w_trig_ok;
        end
    end

    // Period state register and preamble/guard sequence counter
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_state <= ST_CONTROL;
            r_seq   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_seq   <= w_seq_nxt;
        end
    end

    // Next state and per-character period/CTL; the trigger cycle itself is preamble 0
    always_comb begin
        w_state_nxt = r_state;
        w_seq_nxt   = r_seq;
        w_period    = PERIOD_CONTROL;
        w_ctl       = '0;
        if (w_idle) begin
            w_state_nxt = ST_CONTROL;
            w_seq_nxt   = '0;
            if (w_trig_ok) begin
                w_period = PERIOD_PREAMBLE;
                w_ctl    = VIDEO_PREAMBLE_CTL;
                if (PREAMBLE_LEN > 1) begin
                    w_state_nxt = ST_PREAMBLE;
                    w_seq_nxt   = SEQ_W'(1);
                end else begin
                    w_state_nxt = ST_GUARD;
                end
            end
        end else begin
            case (r_state)
                ST_PREAMBLE: begin
                    w_period = PERIOD_PREAMBLE;
                    w_ctl    = VIDEO_PREAMBLE_CTL;
                    if (r_seq == SEQ_W'(PREAMBLE_LEN - 1)) begin
                        w_state_nxt = ST_GUARD;
                        w_seq_nxt   = '0;
                    end else begin
                        w_seq_nxt = r_seq + 1'b1;
                    end
                end
                ST_GUARD: begin
                    w_period = PERIOD_GUARD;
                    if (r_seq == SEQ_W'(GUARD_LEN - 1)) begin
                        w_state_nxt = ST_VIDEO;
                        w_seq_nxt   = '0;
                    end else begin
                        w_seq_nxt = r_seq + 1'b1;
                    end
                end
                default: begin
                    w_period = PERIOD_CONTROL;
                end
            endcase
        end
        // Active video on the output is always VIDEO, inserted or not
        if (de_o) begin
            w_period = PERIOD_VIDEO;
        end
    end

    assign period     = w_period;
    assign ctl        = w_ctl;
    assign timing_err = r_err;
`else
    assign period     = de_o ? PERIOD_VIDEO : PERIOD_CONTROL;
    assign ctl        = '0;
    assign timing_err = 1'b0;
`endif

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Testbench for hdmi_period_scheduler: directed line patterns with random
// sync/pixel content; expected outputs are queued per cycle and checked by
// an independent monitor on the falling edge.
module tb_hdmi_period_scheduler;

    localparam int L    = 10;
    localparam int MAXC = 1024;

    logic       pixel_clk = 1'b0;
    logic       rst = 1'b1;
    logic       de = 1'b0;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic [7:0] pd0 = '0;
    logic [7:0] pd1 = '0;
    logic [7:0] pd2 = '0;
    logic       de_o, hs_o, vs_o;
    logic [7:0] pd0_o, pd1_o, pd2_o;
    logic [1:0] period;
    logic [3:0] ctl;
    logic       timing_err;

    hdmi_period_scheduler dut (
        .pixel_clk      (pixel_clk),
        .rst            (rst),
        .de             (de),
        .hsync          (hsync),
        .vsync          (vsync),
        .pixel_data_0   (pd0),
        .pixel_data_1   (pd1),
        .pixel_data_2   (pd2),
        .de_o           (de_o),
        .hsync_o        (hs_o),
        .vsync_o        (vs_o),
        .pixel_data_0_o (pd0_o),
        .pixel_data_1_o (pd1_o),
        .pixel_data_2_o (pd2_o),
        .period         (period),
        .ctl            (ctl),
        .timing_err     (timing_err)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct packed {
        logic        skip;
        logic [26:0] data;
        logic [1:0]  per;
        logic [3:0]  ctl;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [26:0] in_rec   [MAXC];
    logic [1:0]  plan_per [MAXC];
    logic        plan_err [MAXC];
    int          cyc = 0;
    int          last_rst = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // ev: 0 = nothing, 1 = de rise with enough blanking, 2 = de rise that must flag timing_err
    task automatic step(input logic r, input logic d, input int ev);
        exp_t        e;
        logic [26:0] dd;
        @(posedge pixel_clk);
        #1;
        cyc++;
        rst   = r;
        de    = d;
        hsync = 1'($urandom);
        vsync = 1'($urandom);
        pd0   = 8'($urandom);
        pd1   = 8'($urandom);
        pd2   = 8'($urandom);
        in_rec[cyc] = r ? 27'd0 : {d, hsync, vsync, pd2, pd1, pd0};
        if (r) begin
            last_rst = cyc;
            for (int k = cyc + 1; k < MAXC; k++) begin
                plan_per[k] = 2'd0;
                plan_err[k] = 1'b0;
            end
        end
        if (ev == 1) begin
            for (int k = 0; k < 8; k++) plan_per[cyc + k] = 2'd1;
            for (int k = 8; k < 10; k++) plan_per[cyc + k] = 2'd2;
        end else if (ev == 2) begin
            plan_err[cyc + 1] = 1'b1;
        end
        dd = (cyc - last_rst <= L) ? 27'd0 : in_rec[cyc - L];
        e.skip = r;
        e.data = dd;
`ifdef HDMI_PERIOD_HDMI_MODE_EN
        e.per = dd[26] ? 2'd3 : plan_per[cyc];
        e.ctl = (!dd[26] && plan_per[cyc] == 2'd1) ? 4'b0001 : 4'b0000;
        e.err = plan_err[cyc];
`else
        e.per = dd[26] ? 2'd3 : 2'd0;
        e.ctl = 4'b0000;
        e.err = 1'b0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic run(input logic d, input int n, input int ev_first);
        for (int i = 0; i < n; i++) step(1'b0, d, (i == 0) ? ev_first : 0);
    endtask

    // Monitor: compare every presented output cycle against the queued expectation
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge pixel_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (!e.skip) begin
                    chk("de_o",       32'(de_o),       32'(e.data[26]));
                    chk("hsync_o",    32'(hs_o),       32'(e.data[25]));
                    chk("vsync_o",    32'(vs_o),       32'(e.data[24]));
                    chk("pixel2_o",   32'(pd2_o),      32'(e.data[23:16]));
                    chk("pixel1_o",   32'(pd1_o),      32'(e.data[15:8]));
                    chk("pixel0_o",   32'(pd0_o),      32'(e.data[7:0]));
                    chk("period",     32'(period),     32'(e.per));
                    chk("ctl",        32'(ctl),        32'(e.ctl));
                    chk("timing_err", 32'(timing_err), 32'(e.err));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        for (int k = 0; k < MAXC; k++) begin
            in_rec[k]   = '0;
            plan_per[k] = '0;
            plan_err[k] = '0;
        end
        repeat (5) step(1'b1, 1'b0, 0);
        // long blanking then a 16-cycle line: full preamble and guard
        run(1'b0, 20, 0);
        run(1'b1, 16, 1);
        // 11-cycle blanking: too short, error and straight CONTROL->VIDEO
        run(1'b0, 11, 0);
        run(1'b1, 8, 2);
        // exactly 12-cycle blanking: insertion, two CONTROL cycles before preamble
        run(1'b0, 12, 0);
        run(1'b1, 6, 1);
        // de rise during the preamble: error, sequence undisturbed
        run(1'b0, 20, 0);
        run(1'b1, 2, 1);
        run(1'b0, 2, 0);
        run(1'b1, 3, 2);
        // reset during preamble cycle 4, then a normal line
        run(1'b0, 20, 0);
        run(1'b1, 4, 1);
        step(1'b1, 1'b0, 0);
        run(1'b0, 20, 0);
        run(1'b1, 8, 1);
        run(1'b0, 15, 0);
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
